// File: rtl/snake_pkg.sv
// snake_pkg: shared definitions for the snake game sequencer.
//   - tile codes stored in the tile-map RAM
//   - direction codes for dir_in
//   - sequencer state encoding
//   - default grid geometry and small helper functions
package snake_pkg;

  localparam int DEF_GRID_W = 30;
  localparam int DEF_GRID_H = 17;

  localparam logic [1:0] TILE_EMPTY = 2'd0;
  localparam logic [1:0] TILE_BODY  = 2'd1;
  localparam logic [1:0] TILE_FOOD  = 2'd2;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  typedef enum logic [3:0] {
    S_CLEAR,
    S_PLACE,
    S_FOOD_RD,
    S_FOOD_CHK,
    S_WAIT,
    S_CALC,
    S_CHECK,
    S_TAIL,
    S_HEAD,
    S_DEAD
  } state_t;

  function automatic logic [9:0] xy_to_addr(input logic [4:0] x, input logic [4:0] y,
                                            input int w);
    return 10'(int'(y) * w + int'(x));
  endfunction

  // Fibonacci LFSR, taps 16,14,13,11.
  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

endpackage

// File: rtl/snake_body_fifo.sv
// snake_body_fifo: ring buffer of tile addresses occupied by the snake body.
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_clr               synchronous empty (used while the map is being cleared)
//   i_push_head         append i_push_addr as the new head
//   i_pop_tail          drop the oldest entry (the tail)
//   o_head_addr         newest entry, combinational
//   o_tail_addr         oldest entry, combinational
//   o_len, o_full       occupancy
// A push while full is accepted only if a pop happens in the same cycle.
module snake_body_fifo #(
  parameter int MAX_LEN = 64,
  parameter int AW      = 10,
  localparam int PW     = $clog2(MAX_LEN),
  localparam int LW     = $clog2(MAX_LEN + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clr,
  input  logic          i_push_head,
  input  logic [AW-1:0] i_push_addr,
  input  logic          i_pop_tail,
  output logic [AW-1:0] o_head_addr,
  output logic [AW-1:0] o_tail_addr,
  output logic [LW-1:0] o_len,
  output logic          o_full
);

  logic [AW-1:0] r_mem [MAX_LEN];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [LW-1:0] r_len;
  logic [PW-1:0] w_head_ptr;
  logic          w_do_pop;
  logic          w_do_push;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_LEN - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_head_ptr  = (r_wr_ptr == '0) ? PW'(MAX_LEN - 1) : r_wr_ptr - 1'b1;
  assign w_do_pop    = i_pop_tail && (r_len != '0);
  assign w_do_push   = i_push_head && (!o_full || w_do_pop);
  assign o_head_addr = r_mem[w_head_ptr];
  assign o_tail_addr = r_mem[r_rd_ptr];
  assign o_len       = r_len;
  assign o_full      = (r_len == LW'(MAX_LEN));

  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_clr) r_mem[r_wr_ptr] <= i_push_addr;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_len    <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_len    <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_do_push && !w_do_pop)      r_len <= r_len + 1'b1;
      else if (w_do_pop && !w_do_push) r_len <= r_len - 1'b1;
    end
  end

endmodule

// File: rtl/snake_sched.sv
// snake_sched: game-logic sequencer owning the write port of the tile-map RAM.
//   clk, rest_n            pixel clock, asynchronous active-low reset
//   frame_start            one-cycle pulse at start of vertical blanking
//   dir_in, dir_valid      requested direction; dir_valid in DEAD restarts
//   tm_addr/tm_we/tm_wdata tile-map port (registered)
//   tm_rdata               read data, valid one cycle after a read address
//   score, game_over, busy status (registered)
//   dbg_state, dbg_len     sequencer state and body length for observation
// Tile-map port protocol: a cycle with tm_we=1 is a write of tm_wdata at
// tm_addr and lasts exactly one cycle. A cycle with tm_we=0 presents tm_addr
// as a read; the RAM registers it on the next edge, so the sequencer spends one
// extra cycle in FOOD_CHK/CHECK before sampling tm_rdata.
module snake_sched
  import snake_pkg::*;
#(
  parameter int GRID_W      = DEF_GRID_W,
  parameter int GRID_H      = DEF_GRID_H,
  parameter int MAX_LEN     = 64,
  parameter int TICK_FRAMES = 8,
  parameter int START_X     = 15,
  parameter int START_Y     = 8,
  parameter int START_LEN   = 3
) (
  input  logic                           clk,
  input  logic                           rest_n,
  input  logic                           frame_start,
  input  logic [1:0]                     dir_in,
  input  logic                           dir_valid,
  output logic [9:0]                     tm_addr,
  output logic                           tm_we,
  output logic [1:0]                     tm_wdata,
  input  logic [1:0]                     tm_rdata,
  output logic [7:0]                     score,
  output logic                           game_over,
  output logic                           busy,
  output state_t                         dbg_state,
  output logic [$clog2(MAX_LEN+1)-1:0]   dbg_len
);

  localparam logic [9:0] LAST_ADDR  = 10'(GRID_W * GRID_H - 1);
  localparam logic [9:0] MAP_SIZE   = 10'(GRID_W * GRID_H);
  localparam logic [9:0] HEAD0      = xy_to_addr(5'(START_X), 5'(START_Y), GRID_W);
  localparam logic [9:0] TAIL0      = HEAD0 - 10'(START_LEN - 1);
  localparam logic [9:0] PLACE_LAST = 10'(START_LEN - 1);
  localparam logic [7:0] LAST_FRAME = 8'(TICK_FRAMES - 1);

  state_t      r_state;
  logic [9:0]  r_addr;
  logic        r_we;
  logic [1:0]  r_wdata;
  logic [7:0]  r_score;
  logic        r_over;
  logic        r_busy;
  logic [7:0]  r_frame_cnt;
  logic [1:0]  r_dir;
  logic [1:0]  r_pend;
  logic [15:0] r_lfsr;
  logic [9:0]  r_idx;
  logic        r_rd_wait;
  logic        r_food_hit;
  logic [9:0]  r_naddr;
  logic [4:0]  r_nx, r_ny;
  logic [4:0]  r_hx, r_hy;

  logic [9:0]  w_head_addr, w_tail_addr, w_push_addr, w_naddr;
  logic [$clog2(MAX_LEN+1)-1:0] w_len;
  logic        w_full, w_push, w_pop, w_clr, w_wall;
  logic [4:0]  w_nx, w_ny;

  // Tail-first push order while PLACE writes the body head-first.
  assign w_push      = (r_state == S_PLACE) || (r_state == S_HEAD);
  assign w_push_addr = (r_state == S_PLACE) ? TAIL0 + r_idx : r_naddr;
  assign w_pop       = (r_state == S_TAIL);
  assign w_clr       = (r_state == S_CLEAR);

  snake_body_fifo #(.MAX_LEN(MAX_LEN), .AW(10)) u_body (
    .i_clk       (clk),
    .i_rst_n     (rest_n),
    .i_clr       (w_clr),
    .i_push_head (w_push),
    .i_push_addr (w_push_addr),
    .i_pop_tail  (w_pop),
    .o_head_addr (w_head_addr),
    .o_tail_addr (w_tail_addr),
    .o_len       (w_len),
    .o_full      (w_full)
  );

  // Next head for the direction that CALC commits (the pending one).
  always_comb begin
    w_nx    = r_hx;
    w_ny    = r_hy;
    w_naddr = w_head_addr;
    w_wall  = 1'b0;
    case (r_pend)
      DIR_UP:    begin w_wall = (r_hy == 5'd0);           w_ny = r_hy - 5'd1; w_naddr = w_head_addr - 10'(GRID_W); end
      DIR_RIGHT: begin w_wall = (r_hx == 5'(GRID_W - 1)); w_nx = r_hx + 5'd1; w_naddr = w_head_addr + 10'd1;       end
      DIR_DOWN:  begin w_wall = (r_hy == 5'(GRID_H - 1)); w_ny = r_hy + 5'd1; w_naddr = w_head_addr + 10'(GRID_W); end
      default:   begin w_wall = (r_hx == 5'd0);           w_nx = r_hx - 5'd1; w_naddr = w_head_addr - 10'd1;       end
    endcase
  end

  always_ff @(posedge clk or negedge rest_n) begin
    if (!rest_n) r_lfsr <= 16'hACE1;
    else         r_lfsr <= lfsr_next(r_lfsr);
  end

  always_ff @(posedge clk or negedge rest_n) begin
    if (!rest_n) begin
      r_state     <= S_CLEAR;
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_wdata     <= TILE_EMPTY;
      r_score     <= '0;
      r_over      <= 1'b0;
      r_busy      <= 1'b1;
      r_frame_cnt <= '0;
      r_dir       <= DIR_RIGHT;
      r_pend      <= DIR_RIGHT;
      r_idx       <= '0;
      r_rd_wait   <= 1'b0;
      r_food_hit  <= 1'b0;
      r_naddr     <= '0;
      r_nx        <= '0;
      r_ny        <= '0;
      r_hx        <= '0;
      r_hy        <= '0;
    end else begin
      r_we <= 1'b0;
      // Reversal onto the neck is ignored.
      if (dir_valid && ((dir_in ^ r_dir) != 2'd2)) r_pend <= dir_in;
      case (r_state)
        S_CLEAR: begin
          r_addr  <= r_idx;
          r_we    <= 1'b1;
          r_wdata <= TILE_EMPTY;
          if (r_idx == LAST_ADDR) begin
            r_idx   <= '0;
            r_state <= S_PLACE;
          end else r_idx <= r_idx + 10'd1;
        end
        S_PLACE: begin
          r_addr  <= HEAD0 - r_idx;
          r_we    <= 1'b1;
          r_wdata <= TILE_BODY;
          if (r_idx == PLACE_LAST) begin
            r_idx   <= '0;
            r_hx    <= 5'(START_X);
            r_hy    <= 5'(START_Y);
            r_state <= S_FOOD_RD;
          end else r_idx <= r_idx + 10'd1;
        end
        S_FOOD_RD: begin
          if (r_lfsr[9:0] < MAP_SIZE) begin
            r_addr  <= r_lfsr[9:0];
            r_state <= S_FOOD_CHK;
          end
        end
        S_FOOD_CHK: begin
          if (!r_rd_wait) r_rd_wait <= 1'b1;
          else begin
            r_rd_wait <= 1'b0;
            if (tm_rdata == TILE_EMPTY) begin
              r_we    <= 1'b1;
              r_wdata <= TILE_FOOD;
              r_busy  <= 1'b0;
              r_state <= S_WAIT;
            end else r_state <= S_FOOD_RD;
          end
        end
        S_WAIT: begin
          if (frame_start) begin
            if (r_frame_cnt == LAST_FRAME) begin
              r_frame_cnt <= '0;
              r_busy      <= 1'b1;
              r_state     <= S_CALC;
            end else r_frame_cnt <= r_frame_cnt + 8'd1;
          end
        end
        S_CALC: begin
          r_dir <= r_pend;
          if (w_wall) begin
            r_over  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DEAD;
          end else begin
            r_naddr <= w_naddr;
            r_nx    <= w_nx;
            r_ny    <= w_ny;
            r_addr  <= w_naddr;
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (!r_rd_wait) r_rd_wait <= 1'b1;
          else begin
            r_rd_wait  <= 1'b0;
            r_food_hit <= (tm_rdata == TILE_FOOD);
            if (tm_rdata == TILE_FOOD && !w_full) r_state <= S_HEAD;
            else if (tm_rdata == TILE_BODY && r_naddr != w_tail_addr) begin
              r_over  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_DEAD;
            end else r_state <= S_TAIL;
          end
        end
        S_TAIL: begin
          // Moving into the vacating tail cell: skip the erase, HEAD rewrites it.
          if (r_naddr != w_tail_addr) begin
            r_addr  <= w_tail_addr;
            r_we    <= 1'b1;
            r_wdata <= TILE_EMPTY;
          end
          r_state <= S_HEAD;
        end
        S_HEAD: begin
          r_addr  <= r_naddr;
          r_we    <= 1'b1;
          r_wdata <= TILE_BODY;
          r_hx    <= r_nx;
          r_hy    <= r_ny;
          if (r_food_hit) begin
            if (r_score != 8'hFF) r_score <= r_score + 8'd1;
            r_state <= S_FOOD_RD;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_WAIT;
          end
        end
        S_DEAD: begin
          if (dir_valid) begin
            r_score     <= '0;
            r_over      <= 1'b0;
            r_busy      <= 1'b1;
            r_dir       <= DIR_RIGHT;
            r_pend      <= DIR_RIGHT;
            r_idx       <= '0;
            r_frame_cnt <= '0;
            r_state     <= S_CLEAR;
          end
        end
        default: r_state <= S_CLEAR;
      endcase
    end
  end

  assign tm_addr   = r_addr;
  assign tm_we     = r_we;
  assign tm_wdata  = r_wdata;
  assign score     = r_score;
  assign game_over = r_over;
  assign busy      = r_busy;
  assign dbg_state = r_state;
  assign dbg_len   = w_len;

endmodule

// File: tb/tb_snake_sched.sv
module tb_snake_sched;
  import snake_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rest_n = 1'b0;
  always #5 clk = ~clk;

  logic       frame_start = 1'b0;
  logic [1:0] dir_in = 2'd0;
  logic       dir_valid = 1'b0;
  logic [9:0] tm_addr;
  logic       tm_we;
  logic [1:0] tm_wdata;
  logic [1:0] tm_rdata;
  logic [7:0] score;
  logic       game_over;
  logic       busy;
  state_t     dbg_state;
  logic [6:0] dbg_len;

  snake_sched dut (
    .clk         (clk),
    .rest_n      (rest_n),
    .frame_start (frame_start),
    .dir_in      (dir_in),
    .dir_valid   (dir_valid),
    .tm_addr     (tm_addr),
    .tm_we       (tm_we),
    .tm_wdata    (tm_wdata),
    .tm_rdata    (tm_rdata),
    .score       (score),
    .game_over   (game_over),
    .busy        (busy),
    .dbg_state   (dbg_state),
    .dbg_len     (dbg_len)
  );

  // ---------------- tile RAM model + write monitor ----------------
  logic [1:0]  ram [1024];
  logic [1:0]  rd_q;
  logic        force_en = 1'b0;
  logic [1:0]  force_val = 2'd0;
  logic [11:0] obs_q[$];

  always @(posedge clk) begin
    if (tm_we) begin
      ram[tm_addr] <= tm_wdata;
      obs_q.push_back({tm_addr, tm_wdata});
    end
    rd_q <= ram[tm_addr];
  end

  // Move-target reads can be overridden so the outcome of each move is fixed.
  assign tm_rdata = (force_en && dbg_state == S_CHECK) ? force_val : rd_q;

  // ---------------- scoreboard ----------------
  int          n_vec = 0;
  int          n_err = 0;
  int          obs_rd = 0;
  logic [11:0] exp_q[$];
  logic [9:0]  body_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic pulse_frames(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) frame_start = 1'b1;
      @(negedge clk) frame_start = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic send_dir(input logic [1:0] d);
    @(negedge clk) begin dir_in = d; dir_valid = 1'b1; end
    @(negedge clk) dir_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    @(negedge clk);
    while (busy && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_exp(input string tag);
    int n = exp_q.size();
    chk({tag, "_count"}, 32'(obs_q.size() - obs_rd), 32'(n));
    for (int i = 0; i < n; i++)
      chk({tag, "_write"}, 32'(obs_q[obs_rd + i]), 32'(exp_q[i]));
    exp_q.delete();
    obs_rd = obs_q.size();
  endtask

  task automatic tick_move(input logic [9:0] head, input bit food);
    logic [11:0] f;
    int          hit;
    obs_rd = obs_q.size();
    pulse_frames(7);
    chk("pulses_1_7_no_write", 32'(obs_q.size() - obs_rd), 32'd0);
    pulse_frames(1);
    wait_idle("move");
    if (!food) begin
      exp_q.push_back({body_q.pop_front(), TILE_EMPTY});
      exp_q.push_back({head, TILE_BODY});
      body_q.push_back(head);
      check_exp("move");
    end else begin
      body_q.push_back(head);
      chk("food_count", 32'(obs_q.size() - obs_rd), 32'd2);
      chk("food_head", 32'(obs_q[obs_rd]), 32'({head, TILE_BODY}));
      f = obs_q[obs_rd + 1];
      chk("food_code", 32'(f[1:0]), 32'(TILE_FOOD));
      chk("food_in_grid", 32'(f[11:2] < 10'd510), 32'd1);
      hit = 0;
      foreach (body_q[i]) if (body_q[i] == f[11:2]) hit++;
      chk("food_not_on_body", 32'(hit), 32'd0);
      obs_rd = obs_q.size();
    end
  endtask

  task automatic check_start(input string tag);
    int bad = 0;
    logic [11:0] f;
    chk({tag, "_count"}, 32'(obs_q.size() - obs_rd), 32'd514);
    for (int i = 0; i < 510; i++)
      if (obs_q[obs_rd + i] !== {10'(i), TILE_EMPTY}) bad++;
    chk({tag, "_clear_bad"}, 32'(bad), 32'd0);
    chk({tag, "_body0"}, 32'(obs_q[obs_rd + 510]), 32'({10'd255, TILE_BODY}));
    chk({tag, "_body1"}, 32'(obs_q[obs_rd + 511]), 32'({10'd254, TILE_BODY}));
    chk({tag, "_body2"}, 32'(obs_q[obs_rd + 512]), 32'({10'd253, TILE_BODY}));
    f = obs_q[obs_rd + 513];
    chk({tag, "_food_code"}, 32'(f[1:0]), 32'(TILE_FOOD));
    chk({tag, "_food_pos"}, 32'(f[11:2] < 10'd510 && (f[11:2] < 10'd253 || f[11:2] > 10'd255)), 32'd1);
    chk({tag, "_len"}, 32'(dbg_len), 32'd3);
    chk({tag, "_state"}, 32'(dbg_state), 32'(S_WAIT));
    obs_rd = obs_q.size();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int t;
    repeat (3) @(negedge clk);
    chk("rst_we", 32'(tm_we), 32'd0);
    chk("rst_addr", 32'(tm_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_over", 32'(game_over), 32'd0);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(S_CLEAR));

    // Reset in the middle of CLEAR.
    @(negedge clk) rest_n = 1'b1;
    t = 0;
    while (!(tm_we && tm_addr == 10'd200) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("reach_addr200", 32'(tm_addr), 32'd200);
    rest_n = 1'b0;
    #1;
    chk("midrst_we", 32'(tm_we), 32'd0);
    chk("midrst_addr", 32'(tm_addr), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd1);
    chk("midrst_state", 32'(dbg_state), 32'(S_CLEAR));
    @(negedge clk) rest_n = 1'b1;
    obs_rd = obs_q.size();
    wait_idle("start");
    check_start("start");

    // Moves with the target read forced to empty unless noted.
    force_en = 1'b1;
    force_val = TILE_EMPTY;
    body_q = '{10'd253, 10'd254, 10'd255};
    tick_move(10'd256, 1'b0);
    chk("len_after_move", 32'(dbg_len), 32'd3);
    send_dir(DIR_LEFT);                 // reversal, ignored
    tick_move(10'd257, 1'b0);
    send_dir(DIR_UP);
    tick_move(10'd227, 1'b0);

    force_val = TILE_FOOD;
    tick_move(10'd197, 1'b1);
    force_val = TILE_EMPTY;
    chk("score_after_food", 32'(score), 32'd1);
    chk("len_after_food", 32'(dbg_len), 32'd4);

    send_dir(DIR_RIGHT);
    for (int k = 1; k <= 12; k++) tick_move(10'(197 + k), 1'b0);

    // Head at x=29 moving right: wall.
    obs_rd = obs_q.size();
    pulse_frames(8);
    wait_idle("wall");
    chk("dead_over", 32'(game_over), 32'd1);
    chk("dead_state", 32'(dbg_state), 32'(S_DEAD));
    chk("dead_no_write", 32'(obs_q.size() - obs_rd), 32'd0);
    pulse_frames(8);
    chk("dead_stays_quiet", 32'(obs_q.size() - obs_rd), 32'd0);
    chk("dead_score", 32'(score), 32'd1);

    // Restart from DEAD.
    send_dir(DIR_RIGHT);
    chk("restart_over", 32'(game_over), 32'd0);
    chk("restart_score", 32'(score), 32'd0);
    chk("restart_state", 32'(dbg_state), 32'(S_CLEAR));
    wait_idle("restart");
    check_start("restart");
    chk("restart_score_end", 32'(score), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
